// File: rtl/cache_types_pkg.sv
// Types and sizing shared between the cache datapath and its line-to-burst adapter.
package cache_types_pkg;
  localparam int ADDR_W   = 32;
  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int LINE_W   = BEAT_W * BEATS;
  localparam int OFFSET_W = 5;
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } adapter_state_t;
endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Cache line port plus 64-bit burst memory bus, seen from the adapter (master)
// and from the cache/memory environment around it (slave).
interface cacheline_burst_adapter_if;
  import cache_types_pkg::*;

  logic [ADDR_W-1:0] line_address;
  logic [LINE_W-1:0] line_rdata;
  logic [LINE_W-1:0] line_wdata;
  logic              line_read;
  logic              line_write;
  logic              line_resp;

  logic [ADDR_W-1:0] burst_address;
  logic [BEAT_W-1:0] burst_rdata;
  logic [BEAT_W-1:0] burst_wdata;
  logic              burst_read;
  logic              burst_write;
  logic              burst_resp;

  modport master (
    input  line_address, line_wdata, line_read, line_write, burst_rdata, burst_resp,
    output line_rdata, line_resp, burst_address, burst_wdata, burst_read, burst_write
  );

  modport slave (
    output line_address, line_wdata, line_read, line_write, burst_rdata, burst_resp,
    input  line_rdata, line_resp, burst_address, burst_wdata, burst_read, burst_write
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Turns one 256-bit cache line fill or writeback into a 4-beat 64-bit memory
// burst and answers the cache with a single-cycle line_resp.
module cacheline_burst_adapter
  import cache_types_pkg::*;
(
  input logic                       clk,
  input logic                       rst,
  cacheline_burst_adapter_if.master bus
);

  adapter_state_t    state, state_next;
  logic [CNT_W-1:0]  beat_cnt, beat_next;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic              capture;
  logic              fill_beat;
  logic              last_beat;

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= beat_next;
      if (capture)
        addr_q <= {bus.line_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      if (fill_beat)
        rdata_q[beat_cnt*BEAT_W +: BEAT_W] <= bus.burst_rdata;
    end
  end

  // Writeback line is only driven onto the bus while in WR, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture)
      wdata_q <= bus.line_wdata;
  end

  always_comb begin
    state_next      = state;
    beat_next       = beat_cnt;
    capture         = 1'b0;
    fill_beat       = 1'b0;
    bus.line_resp   = 1'b0;
    bus.burst_read  = 1'b0;
    bus.burst_write = 1'b0;
    bus.burst_wdata = '0;
    case (state)
      IDLE: begin
        // Writeback takes priority so a dirty victim leaves before the fill.
        if (bus.line_write) begin
          state_next = WR;
          beat_next  = '0;
          capture    = 1'b1;
        end else if (bus.line_read) begin
          state_next = RD;
          beat_next  = '0;
          capture    = 1'b1;
        end
      end
      RD: begin
        bus.burst_read = 1'b1;
        if (bus.burst_resp) begin
          fill_beat = 1'b1;
          beat_next = beat_cnt + 1'b1;
          if (last_beat)
            state_next = DONE;
        end
      end
      WR: begin
        bus.burst_write = 1'b1;
        bus.burst_wdata = wdata_q[beat_cnt*BEAT_W +: BEAT_W];
        if (bus.burst_resp) begin
          beat_next = beat_cnt + 1'b1;
          if (last_beat)
            state_next = DONE;
        end
      end
      DONE: begin
        bus.line_resp = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.burst_address = addr_q;
  assign bus.line_rdata    = rdata_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Bench for cacheline_burst_adapter: cache-side transactions plus a stalling memory model.
`timescale 1ns/1ps
module tb_cacheline_burst_adapter;
  import cache_types_pkg::*;

  logic clk = 1'b0;
  logic rst;

  cacheline_burst_adapter_if bus();

  cacheline_burst_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                is_rd;
    logic [LINE_W-1:0] line;
  } resp_t;

  resp_t             exp_resp_q[$];
  logic [BEAT_W-1:0] exp_wbeat_q[$];
  logic [BEAT_W-1:0] rd_beats[BEATS];
  logic [31:0]       cur_addr;
  int                stall_cfg, stall_cnt, beat_idx, beats_done, resp_count;
  bit                saw_read;
  int                checks, failures;
  resp_t             mon_r;
  int                lat;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: grants a beat after stall_cfg idle cycles and checks what it accepts.
  always @(negedge clk) begin
    bus.burst_resp = 1'b0;
    if (bus.burst_read) saw_read = 1'b1;
    if (bus.burst_read || bus.burst_write) begin
      check_eq("rd_wr_excl", bus.burst_read & bus.burst_write, 0);
      if (stall_cnt > 0) begin
        stall_cnt--;
      end else begin
        stall_cnt      = stall_cfg;
        bus.burst_resp = 1'b1;
        beats_done++;
        check_eq("burst_addr", bus.burst_address, cur_addr);
        if (bus.burst_read) begin
          bus.burst_rdata = rd_beats[beat_idx];
        end else begin
          check_eq("wbeat_expected", exp_wbeat_q.size() != 0, 1);
          if (exp_wbeat_q.size() != 0)
            check_eq("burst_wdata", bus.burst_wdata, exp_wbeat_q.pop_front());
        end
        beat_idx = (beat_idx + 1) % BEATS;
      end
    end else begin
      stall_cnt = stall_cfg;
      beat_idx  = 0;
    end
  end

  // Response monitor: every line_resp must match a queued expectation.
  always @(negedge clk) begin
    if (rst && bus.line_resp) begin
      resp_count++;
      check_eq("resp_expected", exp_resp_q.size() != 0, 1);
      if (exp_resp_q.size() != 0) begin
        mon_r = exp_resp_q.pop_front();
        if (mon_r.is_rd)
          check_eq("line_rdata", bus.line_rdata, mon_r.line);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after line_resp.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [LINE_W-1:0] wd, input int stall, input bit churn,
                         output int cycles);
    resp_t e;
    stall_cfg = stall;
    cur_addr  = {addr[31:5], 5'b0};
    e.is_rd   = rd && !wr;
    e.line    = {rd_beats[3], rd_beats[2], rd_beats[1], rd_beats[0]};
    if (wr)
      for (int k = 0; k < BEATS; k++) exp_wbeat_q.push_back(wd[k*BEAT_W +: BEAT_W]);
    exp_resp_q.push_back(e);
    bus.line_address = addr;
    bus.line_wdata   = wd;
    bus.line_read    = rd;
    bus.line_write   = wr;
    @(posedge clk); #1;
    bus.line_read  = 1'b0;
    bus.line_write = 1'b0;
    cycles = 2;
    while (!bus.line_resp && cycles < 300) begin
      if (churn) begin
        bus.line_address = $urandom;
        bus.line_wdata   = {8{$urandom}};
      end
      @(posedge clk); #1;
      cycles++;
    end
    check_eq("resp_seen", bus.line_resp, 1);
    @(posedge clk); #1;
    check_eq("resp_pulse", bus.line_resp, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_line_resp"},   bus.line_resp, 0);
    check_eq({tag, "_burst_read"},  bus.burst_read, 0);
    check_eq({tag, "_burst_write"}, bus.burst_write, 0);
    check_eq({tag, "_burst_addr"},  bus.burst_address, 0);
    check_eq({tag, "_burst_wdata"}, bus.burst_wdata, 0);
    check_eq({tag, "_line_rdata"},  bus.line_rdata, 0);
  endtask

  initial begin
    int n;
    rst              = 1'b0;
    bus.line_address = '0;
    bus.line_wdata   = '0;
    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.burst_resp   = 1'b0;
    bus.burst_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-stall fill
    rd_beats = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0, 0, 1'b0, lat);
    check_eq("rd_latency", lat, 6);
    check_eq("rd_addr_aligned", bus.burst_address, 32'h0000_1220);
    check_eq("rd_line", bus.line_rdata,
             256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Writeback with two stall cycles before each beat
    run_txn(1'b0, 1'b1, 32'h8000_00E0, {64'd4, 64'd3, 64'd2, 64'd1}, 2, 1'b0, lat);
    check_eq("wr_stall_latency", lat, 14);
    check_eq("wr_beats_drained", exp_wbeat_q.size(), 0);

    // Read and write together: write wins, no read burst at all
    saw_read = 1'b0;
    run_txn(1'b1, 1'b1, 32'h0000_4057, {4{$urandom, $urandom}}, 0, 1'b0, lat);
    check_eq("both_no_read", saw_read, 0);
    check_eq("both_addr", bus.burst_address, 32'h0000_4040);

    // Cache inputs churn every cycle during a stalled writeback
    run_txn(1'b0, 1'b1, 32'h1234_567F, {8{$urandom}}, 1, 1'b1, lat);
    check_eq("churn_addr", bus.burst_address, 32'h1234_5660);

    // Reset after two fill beats
    rd_beats   = '{64'hA0A0_0000_0000_0001, 64'hA0A0_0000_0000_0002,
                   64'hA0A0_0000_0000_0003, 64'hA0A0_0000_0000_0004};
    stall_cfg  = 0;
    cur_addr   = 32'h0000_2000;
    beats_done = 0;
    n          = resp_count;
    bus.line_address = 32'h0000_2000;
    bus.line_read    = 1'b1;
    @(posedge clk); #1;
    bus.line_read = 1'b0;
    for (int i = 0; i < 50 && beats_done < 2; i++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_two_beats", beats_done, 2);
    rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("postrst_idle_read", bus.burst_read, 0);
    check_eq("postrst_no_resp", resp_count, n);
    run_txn(1'b1, 1'b0, 32'h0000_2010, '0, 0, 1'b0, lat);
    check_eq("postrst_latency", lat, 6);
    check_eq("postrst_line", bus.line_rdata,
             256'hA0A0000000000004_A0A0000000000003_A0A0000000000002_A0A0000000000001);

    // Back-to-back writeback then fill
    run_txn(1'b0, 1'b1, 32'h0000_3000, {8{$urandom}}, 0, 1'b0, lat);
    rd_beats = '{64'hDEAD_BEEF_0000_0000, 64'hDEAD_BEEF_1111_1111,
                 64'hDEAD_BEEF_2222_2222, 64'hDEAD_BEEF_3333_3333};
    run_txn(1'b1, 1'b0, 32'h0000_3040, '0, 0, 1'b0, lat);
    check_eq("b2b_rd_latency", lat, 6);
    check_eq("b2b_line", bus.line_rdata,
             256'hDEADBEEF33333333_DEADBEEF22222222_DEADBEEF11111111_DEADBEEF00000000);

    repeat (2) @(posedge clk);
    #1;
    check_eq("resp_total", resp_count, 7);
    check_eq("resp_q_empty", exp_resp_q.size(), 0);
    check_eq("wbeat_q_empty", exp_wbeat_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
Sits directly downstream of the cache, between its 256-bit line port (pmem_*) and the 64-bit burst main-memory bus. Converts one line read (fill) or line write (writeback) into a 4-beat burst. Captures the request, sequences the beats with a beat counter, then returns a single-cycle line_resp to the cache.

Parameters:
BEAT_W, 64, width of one memory beat in bits
BEATS, 4, beats per cache line
LINE_W, 256, cache line width (must equal BEAT_W*BEATS)
OFFSET_W, 5, line-offset bits forced to zero on burst_address

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
line_address  in  32  line request address from cache (pmem_address)
line_rdata  out  256  assembled fill line to cache (pmem_rdata)
line_wdata  in  256  writeback line from cache (pmem_wdata)
line_read  in  1  cache line-read request
line_write  in  1  cache line-write request
line_resp  out  1  one-cycle completion pulse to cache (pmem_resp)
burst_address  out  32  line-aligned burst address
burst_rdata  in  64  read beat from memory
burst_wdata  out  64  write beat to memory
burst_read  out  1  burst read request, held until last beat
burst_write  out  1  burst write request, held until last beat
burst_resp  in  1  beat accepted/valid this cycle

Behaviour:
- Reset (rst=0, async): state=IDLE, beat_cnt=0, line_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, line_rdata=0. Reset mid-burst abandons the burst; memory side is reset in the same domain.
- States: IDLE, RD, WR, DONE.
- IDLE: on line_write -> capture {line_address[31:5],5'b0} and line_wdata, beat_cnt=0, go WR. Else on line_read -> capture address, go RD. Both asserted: write wins (writeback before fill); cache must not do this, bench flags it.
- RD: burst_read=1, burst_address=captured. Each cycle with burst_resp=1: line_rdata[64*beat_cnt +: 64] <= burst_rdata, beat_cnt++. Beats may be non-consecutive (resp low = stall, no advance). On beat BEATS-1 -> DONE, burst_read drops the next cycle.
- WR: burst_write=1, burst_wdata = captured_wdata[64*beat_cnt +: 64] (combinational from counter). Each burst_resp=1 advances beat_cnt; on beat BEATS-1 -> DONE.
- DONE: line_resp=1 for exactly one cycle, burst_read/burst_write=0, then IDLE. New request not accepted in DONE; earliest next acceptance is the cycle after line_resp (cache has deasserted its request by then).
- Beat order: beat 0 = bits [63:0] (lowest address), beat 3 = bits [255:192].
- beat_cnt is 2 bits, wraps 3->0 on final beat; never observed outside RD/WR.
- line_rdata holds last completed fill until next RD overwrites; valid when line_resp=1 after a read.
- Captured address/wdata are stable for the whole burst even if cache inputs change.
- Latency: request cycle -> burst_* asserted next cycle; with zero-stall memory, line_resp 6 cycles after request (1 capture + 4 beats + 1 DONE).
- burst_resp in IDLE/DONE ignored.

Decomposition:
- Package cache_types_pkg: adapter_state_t enum {IDLE,RD,WR,DONE}, BEAT_W, BEATS, LINE_W, OFFSET_W constants shared with the cache datapath.
- No sub-module required; beat counter and state register live in one always_ff, output decode in one always_comb.

Test Plan:
- Read, no stalls: line_read addr 0x0000_1234, memory beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> burst_address 0x0000_1220, line_rdata = {44..,33..,22..,11..}, line_resp single pulse at cycle 6.
- Write, stalls: line_write addr 0x8000_00E0, wdata beat k = k+1 replicated, burst_resp held low 2 cycles before each beat -> burst_wdata sequence 1,2,3,4, burst_write held through last beat, one line_resp.
- Simultaneous line_read and line_write -> WR burst performed, burst_read never asserted.
- Input churn: change line_address/line_wdata every cycle mid-burst -> burst_address/burst_wdata unaffected.
- Reset mid-read after 2 beats (rst low 1 cycle) -> all outputs 0 immediately, state IDLE, no line_resp; next read completes normally.
- Back-to-back: write then read issued the cycle after line_resp -> two complete bursts, two line_resp pulses, correct rdata.
